// File: rtl/chan_scan_pkg.sv
// Shared types and helpers for the channel scan multiplexer.
// The clog2 helper sizes the channel index and dwell/blank counter ports.
package chan_scan_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam logic MODE_AUTO   = 1'b0;
    localparam logic MODE_MANUAL = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_next_ch.sv
// Combinational round-robin search: lowest enabled index above cur, else lowest enabled.
// wrapped is set when the chosen index is not above cur (including cur itself).
module rr_next_ch
    import chan_scan_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [clog2(N_CH)-1:0] cur,
    input  logic [N_CH-1:0]        mask,
    output logic [clog2(N_CH)-1:0] next_ch,
    output logic                   found,
    output logic                   wrapped
);

    localparam int IDX_W = clog2(N_CH);

    logic [IDX_W-1:0] above;
    logic [IDX_W-1:0] lowest;
    logic             any_above;
    logic             any_set;

    // Scan downwards so the last hit in each category is the lowest index.
    always_comb begin
        above     = '0;
        lowest    = '0;
        any_above = 1'b0;
        any_set   = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (mask[k]) begin
                lowest  = IDX_W'(k);
                any_set = 1'b1;
                if (k > int'(cur)) begin
                    above     = IDX_W'(k);
                    any_above = 1'b1;
                end
            end
        end
    end

    assign found   = any_set;
    assign next_ch = any_above ? above : lowest;
    assign wrapped = any_set && !any_above;

endmodule

// File: rtl/chan_scan_mux.sv
// Registered N-channel time-multiplexing selector with fixed dwell and blanking gap.
// Scans enabled channels round-robin or holds a qualified manual channel.
module chan_scan_mux
    import chan_scan_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int DWELL = 100000,
    parameter int BLANK = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*W-1:0]      in_bus,
    input  logic                   mode,
    input  logic [clog2(N_CH)-1:0] man_sel,
    input  logic [N_CH-1:0]        en_mask,
    output logic [W-1:0]           out,
    output logic [N_CH-1:0]        sel_onehot,
    output logic                   valid,
    output logic                   wrap
);

    localparam int IDX_W   = clog2(N_CH);
    localparam int MASK_W  = 1 << IDX_W;
    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = (clog2(CNT_MAX) > 0) ? clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] ch;
    logic             first;

    logic [MASK_W-1:0] mask_ext;
    logic [IDX_W-1:0]  rr_next;
    logic              rr_found;
    logic              rr_wrapped;
    logic [IDX_W-1:0]  pick_ch;
    logic              pick_ok;
    logic              pick_wrap;

    // Zero-padding the mask to a power of two makes out-of-range man_sel read as disabled.
    assign mask_ext = MASK_W'(en_mask);

    rr_next_ch #(.N_CH(N_CH)) u_rr (
        .cur     (ch),
        .mask    (en_mask),
        .next_ch (rr_next),
        .found   (rr_found),
        .wrapped (rr_wrapped)
    );

    always_comb begin
        pick_ok   = 1'b0;
        pick_ch   = ch;
        pick_wrap = 1'b0;
        if (mode == MODE_MANUAL) begin
            pick_ok   = mask_ext[man_sel];
            pick_ch   = man_sel;
            pick_wrap = (man_sel <= ch);
        end else begin
            pick_ok   = rr_found;
            pick_ch   = rr_next;
            pick_wrap = rr_wrapped;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            ch         <= IDX_W'(N_CH - 1);
            first      <= 1'b1;
            out        <= '0;
            sel_onehot <= '0;
            valid      <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        cnt <= '0;
                        if (pick_ok) begin
                            state      <= ST_SHOW;
                            ch         <= pick_ch;
                            first      <= 1'b0;
                            wrap       <= pick_wrap && !first;
                            out        <= in_bus[int'(pick_ch)*W +: W];
                            sel_onehot <= N_CH'(1) << pick_ch;
                            valid      <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (!mask_ext[ch] || cnt == DWELL_LAST) begin
                        state      <= ST_BLANK;
                        cnt        <= '0;
                        out        <= '0;
                        sel_onehot <= '0;
                        valid      <= 1'b0;
                    end else begin
                        cnt        <= cnt + 1'b1;
                        out        <= in_bus[int'(ch)*W +: W];
                        sel_onehot <= N_CH'(1) << ch;
                        valid      <= 1'b1;
                    end
                end
                default: state <= ST_BLANK;
            endcase
        end
    end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Bench for chan_scan_mux: fixed vector table, directed corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_chan_scan_mux;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int DW = 3;
    localparam int BK = 1;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] in_bus;
    logic           mode;
    logic [1:0]     man_sel;
    logic [N-1:0]   en_mask;
    logic [W-1:0]   out;
    logic [N-1:0]   sel_onehot;
    logic           valid;
    logic           wrap;

    logic [31:0] in_bus8;
    logic        mode8;
    logic [2:0]  man_sel8;
    logic [7:0]  mask8;
    logic [3:0]  out8;
    logic [7:0]  sel8;
    logic        valid8;
    logic        wrap8;

    int checks = 0;
    int errors = 0;

    chan_scan_mux #(.N_CH(N), .W(W), .DWELL(DW), .BLANK(BK)) dut (
        .clk(clk), .rst(rst), .in_bus(in_bus), .mode(mode), .man_sel(man_sel),
        .en_mask(en_mask), .out(out), .sel_onehot(sel_onehot), .valid(valid), .wrap(wrap)
    );

    chan_scan_mux #(.N_CH(8), .W(4), .DWELL(2), .BLANK(2)) dut8 (
        .clk(clk), .rst(rst), .in_bus(in_bus8), .mode(mode8), .man_sel(man_sel8),
        .en_mask(mask8), .out(out8), .sel_onehot(sel8), .valid(valid8), .wrap(wrap8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase flag plus cycles remaining in the current phase.
    bit       m_show;
    int       m_left;
    int       m_ch;
    bit       m_first;
    bit [7:0] m_out;
    bit [3:0] m_sel;
    bit       m_valid;
    bit       m_wrap;

    function automatic bit [7:0] chan_data(input int c);
        return 8'(in_bus >> (c * W));
    endfunction

    task automatic model_edge();
        int  nc;
        bit  got;
        m_wrap = 1'b0;
        if (rst) begin
            m_show = 0; m_left = BK; m_ch = N - 1; m_first = 1;
            m_out = 0; m_sel = 0; m_valid = 0;
            return;
        end
        if (!m_show) begin
            m_left--;
            if (m_left == 0) begin
                m_left = BK;
                got = 0;
                nc = 0;
                if (mode) begin
                    if (int'(man_sel) < N && en_mask[man_sel]) begin
                        got = 1; nc = int'(man_sel);
                    end
                end else begin
                    for (int i = 1; i <= N; i++)
                        if (!got && en_mask[(m_ch + i) % N]) begin
                            got = 1; nc = (m_ch + i) % N;
                        end
                end
                if (got) begin
                    m_wrap  = !m_first && (nc <= m_ch);
                    m_first = 0;
                    m_ch    = nc;
                    m_show  = 1;
                    m_left  = DW;
                    m_out   = chan_data(nc);
                    m_sel   = 4'(1 << nc);
                    m_valid = 1;
                end
            end
        end else if (!en_mask[m_ch] || m_left == 1) begin
            m_show = 0; m_left = BK;
            m_out = 0; m_sel = 0; m_valid = 0;
        end else begin
            m_left--;
            m_out   = chan_data(m_ch);
            m_sel   = 4'(1 << m_ch);
            m_valid = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       r;
        logic       m;
        logic [1:0] ms;
        logic [3:0] mk;
        logic [7:0] e_out;
        logic [3:0] e_sel;
        logic       e_valid;
        logic       e_wrap;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic m, input logic [1:0] ms,
                                input logic [3:0] mk, input logic [7:0] o,
                                input logic [3:0] s, input logic v, input logic w);
        vec_t e;
        e.r = r; e.m = m; e.ms = ms; e.mk = mk;
        e.e_out = o; e.e_sel = s; e.e_valid = v; e.e_wrap = w;
        tbl.push_back(e);
    endfunction

    initial begin
        bit seen;
        logic [7:0] bytes [4];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;

        rst = 1; mode = 0; man_sel = 0; en_mask = 4'hF; in_bus = 32'h44332211;
        mode8 = 1; man_sel8 = 3'd5; mask8 = 8'hDF; in_bus8 = 32'h76543210;

        // Startup, all channels, auto
        add(1, 0, 0, 4'hF, 0, 0, 0, 0);
        add(1, 0, 0, 4'hF, 0, 0, 0, 0);
        for (int c = 0; c < N; c++) begin
            for (int d = 0; d < DW; d++) add(0, 0, 0, 4'hF, bytes[c], 4'(1 << c), 1, 0);
            add(0, 0, 0, 4'hF, 0, 0, 0, 0);
        end
        add(0, 0, 0, 4'hF, 8'h11, 4'b0001, 1, 1);
        add(0, 0, 0, 4'hF, 8'h11, 4'b0001, 1, 0);
        // Mask skip 1010
        add(1, 0, 0, 4'hA, 0, 0, 0, 0);
        for (int p = 0; p < 2; p++) begin
            for (int d = 0; d < DW; d++) add(0, 0, 0, 4'hA, 8'h22, 4'b0010, 1, (p == 1 && d == 0));
            add(0, 0, 0, 4'hA, 0, 0, 0, 0);
            for (int d = 0; d < DW; d++) add(0, 0, 0, 4'hA, 8'h44, 4'b1000, 1, 0);
            add(0, 0, 0, 4'hA, 0, 0, 0, 0);
        end
        // Manual channel 2
        add(1, 1, 2, 4'hF, 0, 0, 0, 0);
        for (int p = 0; p < 3; p++) begin
            for (int d = 0; d < DW; d++) add(0, 1, 2, 4'hF, 8'h33, 4'b0100, 1, (p > 0 && d == 0));
            add(0, 1, 2, 4'hF, 0, 0, 0, 0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r; mode = tbl[i].m; man_sel = tbl[i].ms; en_mask = tbl[i].mk;
            tick();
            check($sformatf("vec%0d", i), 32'({out, sel_onehot, valid, wrap}),
                  32'({tbl[i].e_out, tbl[i].e_sel, tbl[i].e_valid, tbl[i].e_wrap}));
        end

        // Early drop of the shown channel
        rst = 1; mode = 0; en_mask = 4'hF; in_bus = 32'h44332211;
        tick();
        rst = 0;
        tick();
        check("drop_show", 32'(sel_onehot), 32'h1);
        tick();
        en_mask = 4'hE;
        tick();
        check("drop_blank", 32'({valid, sel_onehot}), 32'h0);
        tick();
        check("drop_next", 32'({out, sel_onehot, wrap}), 32'({8'h22, 4'b0010, 1'b0}));

        // Live data tracking within a dwell
        in_bus = 32'h44335511;
        tick();
        check("live1", 32'(out), 32'h55);
        in_bus = 32'h44339911;
        tick();
        check("live2", 32'(out), 32'h99);

        // Reset mid-SHOW, then restart from ch0
        en_mask = 4'hF; rst = 1;
        tick();
        check("rst_mid", 32'({out, sel_onehot, valid, wrap}), 32'h0);
        rst = 0; in_bus = 32'h44332211;
        tick();
        check("rst_restart", 32'({out, sel_onehot, valid, wrap}), 32'({8'h11, 4'b0001, 1'b1, 1'b0}));

        // Empty mask never shows; manual ch5 disabled on the 8-channel build stays blank
        rst = 1;
        tick();
        rst = 0; en_mask = 4'h0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("mask0", 32'(valid), 32'h0);
            check("man8_blank", 32'({valid8, sel8}), 32'h0);
        end
        mask8 = 8'hFF;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            seen = valid8;
        end
        check("man8_show", 32'({sel8, out8}), 32'({8'h20, 4'h5}));

        // Randomized traffic against the model
        en_mask = 4'hF;
        for (int i = 0; i < 3000; i++) begin
            in_bus = $urandom;
            if ($urandom_range(0, 19) == 0) en_mask = 4'($urandom);
            if ($urandom_range(0, 59) == 0) mode = ~mode;
            if ($urandom_range(0, 24) == 0) man_sel = 2'($urandom);
            rst = ($urandom_range(0, 399) == 0);
            tick();
            check("rand", 32'({out, sel_onehot, valid, wrap}),
                  32'({m_out, m_sel, m_valid, m_wrap}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chan_scan_mux.md
# chan_scan_mux

Parametrised, registered N-channel, W-bit time-multiplexing selector; the successor to the single-bit 2:1 mux on the Basys 3 Wild Cube build. It scans enabled input channels round-robin, or holds a manually chosen channel. Each channel is shown for a fixed dwell, with a blanking gap between channels so downstream drivers (seven-segment anodes, LED column strobes) never see two channels overlap. It sits between the cube/display data sources and the pin-level drivers; active-low inversion is done outside this block.

## Interface
- N_CH, 4, number of input channels (2..16)
- W, 8, data width per channel
- DWELL, 100000, clock cycles each channel is shown (≥1)
- BLANK, 1000, clock cycles of blanking between channels (≥1)
- clk  in  1  system clock; single domain
- rst  in  1  reset, synchronous, active-high
- in_bus  in  N_CH*W  channel k occupies bits [k*W +: W]
- mode  in  1  0 = auto round-robin, 1 = manual
- man_sel  in  clog2(N_CH)  channel index used in manual mode
- en_mask  in  N_CH  per-channel enable; a cleared bit means the channel is skipped
- out  out  W  selected channel data, registered
- sel_onehot  out  N_CH  active-high one-hot strobe for the shown channel; all-zero while blanked
- valid  out  1  high while out/sel_onehot show a channel
- wrap  out  1  one-cycle pulse on entering a scan pass

## Operation
- Reset (rst high at an edge): state=BLANK, cnt=0, ch=N_CH-1, first=1; out=0, sel_onehot=0, valid=0, wrap=0. Reset mid-dwell aborts immediately.
- Two states, BLANK and SHOW.
- BLANK: out=0, sel_onehot=0, valid=0. cnt counts to BLANK-1. On the final cycle, the next channel is chosen:
  - Auto mode: the lowest enabled index greater than ch; otherwise wrap to the lowest enabled index.
  - Manual mode: man_sel if man_sel<N_CH and en_mask[man_sel]=1.
  - If a channel is chosen: ch updates and state moves to SHOW.
  - If none is chosen (mask all zero, or manual channel invalid or disabled): remain in BLANK, cnt reloads, ch is unchanged.
- SHOW: every cycle, out<=in_bus[ch*W +: W], sel_onehot<=1<<ch, valid<=1. The input is not latched once per dwell; it tracks live data with 1-cycle latency. cnt counts to DWELL-1, then state moves to BLANK.
- Early termination: if en_mask[ch] drops during SHOW, the next edge enters BLANK. Changes to mode, man_sel, or other mask bits take effect only at the next BLANK→SHOW decision.
- wrap: pulses for 1 cycle, coincident with the first SHOW cycle, when the new ch ≤ previous ch. It is suppressed on the first SHOW after reset (first clears then). In manual mode, reselecting the same channel pulses wrap every period.
- Single enabled channel in auto mode: that channel repeats; wrap pulses each period.

## Timing
- Latency from in_bus to out: 1 cycle during SHOW.
- out, sel_onehot, and valid change on the same edge; no glitch or overlap between channels is possible.
- Per-channel period: BLANK+DWELL cycles. A full auto pass over k enabled channels takes k*(BLANK+DWELL) cycles.
- First SHOW after rst deasserts: the edge ending cycle BLANK, i.e. sel_onehot is nonzero from cycle BLANK+1 after release.
- cnt width: clog2(max(DWELL,BLANK)). cnt resets to 0 on every state change.

## Structure
- Package chan_scan_pkg holds: state enum (ST_BLANK, ST_SHOW), mode constants (MODE_AUTO=0, MODE_MANUAL=1), and a clog2 helper function.
- Sub-module rr_next_ch is combinational. Inputs: cur index and mask. Outputs: next index, found, wrapped. Priority search from cur+1 with wrap-around, parameterised by N_CH.
- Top level holds: FSM, counter, output registers, and the manual-select qualification.

## Test plan
- Reset/startup: N_CH=4, W=8, DWELL=3, BLANK=1, mask=1111, auto, in_bus=0x44332211. After reset, outputs are 0. Expect out sequence 11,11,11,0,22,22,22,0,33,…; sel_onehot 0001→0010→0100→1000; wrap pulses when returning to ch0, not on the first pass.
- Mask skip: mask=1010. Expect channels 1,3,1,3…, each shown 3 cycles with 1 blank cycle between; wrap on each return to ch1. Mask=0000: valid stays 0 indefinitely.
- Manual mode: mode=1, man_sel=2. Expect ch2 repeated (out=33, sel=0100) with wrap every 4 cycles. Set man_sel=5 on an N_CH=8 build with mask bit 5 cleared: expect permanent BLANK.
- Early drop: clear en_mask[ch] on SHOW cycle 2. Expect valid=0 and sel=0 on the next edge, then the next enabled channel after BLANK.
- Live tracking and reset: change in_bus mid-dwell; expect out to follow one cycle later. Assert rst mid-SHOW; expect all outputs 0 on the next edge and the startup sequence to restart from ch0.
